// File: rtl/pc_pkg.sv
// Shared constants for the next-PC path: candidate source indices and default vectors.
package pc_pkg;

    localparam int PC_SRC_ALU    = 0;
    localparam int PC_SRC_ALUOUT = 1;
    localparam int PC_SRC_JUMP   = 2;
    localparam int PC_SRC_EPC    = 3;
    localparam int PC_SRC_MEM    = 4;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_00FC;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational N:1 next-PC candidate selector with an in-range flag.
module pc_src_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3
) (
    input  logic [SEL_W-1:0]         selector,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    output logic [WIDTH-1:0]         target,
    output logic                     valid
);

    assign valid = (32'(selector) < 32'(NUM_SRC));

    // Out-of-range indices leave target at zero so no slice beyond src_data is touched.
    always_comb begin
        target = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (selector == SEL_W'(i)) begin
                target = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_source_reg.sv
// PC register with N-way next-PC selection, branch gating, exception redirect,
// EPC capture and target alignment checking.
module pc_source_reg
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               NUM_SRC      = 5,
    parameter int               SEL_W        = 3,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
    parameter bit               ALIGN_CHECK  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         selector,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     cond_flag,
    input  logic                     exc_req,
    output logic [WIDTH-1:0]         pc_out,
    output logic [WIDTH-1:0]         epc_out,
    output logic                     fault,
    output logic                     loaded
);

    logic [WIDTH-1:0] target;
    logic             sel_valid;
    logic             load_en;
    logic             misaligned;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic             fault_q;
    logic             loaded_q;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_mux (
        .selector (selector),
        .src_data (src_data),
        .target   (target),
        .valid    (sel_valid)
    );

    assign load_en    = pc_write | (pc_write_cond & cond_flag);
    assign misaligned = ALIGN_CHECK && (target[1:0] != 2'b00);

    // Exception outranks any load; a bad load target redirects like an exception but flags fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            epc_q    <= '0;
            fault_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else if (exc_req) begin
            pc_q     <= EXC_VECTOR;
            epc_q    <= pc_q;
            fault_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else if (load_en && (!sel_valid || misaligned)) begin
            pc_q     <= EXC_VECTOR;
            epc_q    <= pc_q;
            fault_q  <= 1'b1;
            loaded_q <= 1'b0;
        end else if (load_en) begin
            pc_q     <= target;
            fault_q  <= 1'b0;
            loaded_q <= 1'b1;
        end else begin
            fault_q  <= 1'b0;
            loaded_q <= 1'b0;
        end
    end

    assign pc_out  = pc_q;
    assign epc_out = epc_q;
    assign fault   = fault_q;
    assign loaded  = loaded_q;

endmodule

// File: tb/tb_pc_source_reg.sv
// Self-checking bench: two DUTs (alignment check on/off) against a behavioural model.
module tb_pc_source_reg;
    import pc_pkg::*;

    localparam int W = 32;
    localparam int N = 5;
    localparam int S = 3;
    localparam logic [31:0] EXC = 32'h0000_00FC;

    logic         clk = 1'b0;
    logic         reset;
    logic [S-1:0] selector;
    logic [31:0]  src_w [N];
    logic [N*W-1:0] src_data;
    logic         pc_write, pc_write_cond, cond_flag, exc_req;

    logic [31:0]  pc_o  [2];
    logic [31:0]  epc_o [2];
    logic         fault_o  [2];
    logic         loaded_o [2];

    logic [31:0]  m_pc  [2];
    logic [31:0]  m_epc [2];
    logic         m_fault  [2];
    logic         m_loaded [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        src_data = '0;
        for (int i = 0; i < N; i++) src_data[i*W +: W] = src_w[i];
    end

    pc_source_reg #(.ALIGN_CHECK(1'b1)) u_dut_chk (
        .clk(clk), .reset(reset), .selector(selector), .src_data(src_data),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_flag(cond_flag),
        .exc_req(exc_req), .pc_out(pc_o[0]), .epc_out(epc_o[0]),
        .fault(fault_o[0]), .loaded(loaded_o[0]));

    pc_source_reg #(.ALIGN_CHECK(1'b0)) u_dut_nochk (
        .clk(clk), .reset(reset), .selector(selector), .src_data(src_data),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_flag(cond_flag),
        .exc_req(exc_req), .pc_out(pc_o[1]), .epc_out(epc_o[1]),
        .fault(fault_o[1]), .loaded(loaded_o[1]));

    task automatic cmp(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_fault[k] = 1'b0; m_loaded[k] = 1'b0;
        end
    endtask

    // Model of one rising edge, from the rules: exception > bad load > good load > hold.
    task automatic model_edge();
        bit ld, in_range, bad;
        logic [31:0] t;
        for (int k = 0; k < 2; k++) begin
            ld = pc_write || (pc_write_cond && cond_flag);
            in_range = (int'(selector) < N);
            t = in_range ? src_w[selector] : 32'h0;
            bad = !in_range || (k == 0 && t[1:0] != 2'b00);
            if (exc_req) begin
                m_epc[k] = m_pc[k]; m_pc[k] = EXC; m_fault[k] = 0; m_loaded[k] = 0;
            end else if (ld && bad) begin
                m_epc[k] = m_pc[k]; m_pc[k] = EXC; m_fault[k] = 1; m_loaded[k] = 0;
            end else if (ld) begin
                m_pc[k] = t; m_fault[k] = 0; m_loaded[k] = 1;
            end else begin
                m_fault[k] = 0; m_loaded[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            cmp("pc_out", k, pc_o[k], m_pc[k]);
            cmp("epc_out", k, epc_o[k], m_epc[k]);
            cmp("fault", k, 32'(fault_o[k]), 32'(m_fault[k]));
            cmp("loaded", k, 32'(loaded_o[k]), 32'(m_loaded[k]));
            if (fault_o[k] && loaded_o[k]) cmp("fault_and_loaded", k, 32'd1, 32'd0);
        end
    endtask

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; cond_flag = 0; exc_req = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic load(input int sel, input logic [31:0] val);
        idle();
        selector = S'(sel); src_w[sel] = val; pc_write = 1;
        cycle();
        idle();
    endtask

    task automatic async_reset();
        reset = 0;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1;
    endtask

    initial begin
        reset = 0;
        idle();
        selector = '0;
        for (int i = 0; i < N; i++) src_w[i] = 32'h0;
        model_reset();
        #12;
        check_all();
        cmp("lit_reset_pc", 0, pc_o[0], 32'h0);
        @(negedge clk);
        reset = 1;
        cycle();
        cmp("lit_idle_pc", 0, pc_o[0], 32'h0);

        // Unconditional load from the jump source
        load(PC_SRC_JUMP, 32'h0000_1000);
        cmp("lit_load_pc", 0, pc_o[0], 32'h0000_1000);
        cmp("lit_load_loaded", 0, 32'(loaded_o[0]), 32'd1);
        cycle();
        cmp("lit_loaded_pulse", 0, 32'(loaded_o[0]), 32'd0);

        // Conditional branch gating
        selector = S'(PC_SRC_ALU); src_w[0] = 32'h200; pc_write_cond = 1; cond_flag = 0;
        cycle();
        cmp("lit_cond0_pc", 0, pc_o[0], 32'h0000_1000);
        cond_flag = 1;
        cycle();
        cmp("lit_cond1_pc", 0, pc_o[0], 32'h0000_0200);
        idle();

        // Misaligned target: fault on checking DUT, plain load on the other
        load(PC_SRC_JUMP, 32'h0000_1000);
        load(PC_SRC_ALUOUT, 32'h0000_1002);
        cmp("lit_misalign_pc", 0, pc_o[0], 32'h0000_00FC);
        cmp("lit_misalign_epc", 0, epc_o[0], 32'h0000_1000);
        cmp("lit_misalign_fault", 0, 32'(fault_o[0]), 32'd1);
        cmp("lit_noalign_pc", 1, pc_o[1], 32'h0000_1002);
        cycle();
        cmp("lit_fault_pulse", 0, 32'(fault_o[0]), 32'd0);

        // Out-of-range selector
        load(PC_SRC_MEM, 32'h0000_0300);
        idle(); selector = 3'd6; pc_write = 1;
        cycle();
        idle();
        cmp("lit_badsel_pc", 1, pc_o[1], 32'h0000_00FC);
        cmp("lit_badsel_epc", 1, epc_o[1], 32'h0000_0300);
        cmp("lit_badsel_fault", 1, 32'(fault_o[1]), 32'd1);

        // Exception beats a valid load
        load(PC_SRC_JUMP, 32'h0000_0500);
        selector = S'(PC_SRC_EPC); src_w[3] = 32'h0000_0800; pc_write = 1; exc_req = 1;
        cycle();
        idle();
        cmp("lit_exc_pc", 0, pc_o[0], 32'h0000_00FC);
        cmp("lit_exc_epc", 0, epc_o[0], 32'h0000_0500);
        cmp("lit_exc_loaded", 0, 32'(loaded_o[0]), 32'd0);
        cmp("lit_exc_fault", 0, 32'(fault_o[0]), 32'd0);

        // All-ones targets
        load(PC_SRC_ALU, 32'hFFFF_FFFC);
        cmp("lit_wrap_pc", 0, pc_o[0], 32'hFFFF_FFFC);
        load(PC_SRC_ALU, 32'hFFFF_FFFF);
        cmp("lit_ones_pc", 1, pc_o[1], 32'hFFFF_FFFF);

        // Asynchronous reset mid-run
        load(PC_SRC_JUMP, 32'h0000_0040);
        #2;
        async_reset();
        cmp("lit_async_pc", 0, pc_o[0], 32'h0);
        cmp("lit_async_epc", 0, epc_o[0], 32'h0);
        cycle();
        cmp("lit_post_reset_pc", 0, pc_o[0], 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            selector = S'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                src_w[i] = $urandom();
                if ($urandom_range(0, 3) != 0) src_w[i][1:0] = 2'b00;
            end
            pc_write      = ($urandom_range(0, 2) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            cond_flag     = $urandom_range(0, 1) == 1;
            exc_req       = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                async_reset();
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_source_reg.md
Name: pc_source_reg

Overview:
- Parametrised successor to the multicycle CPU's PC-input mux: N-way next-PC selection, the PC register itself, conditional-branch write gating, exception redirection with EPC capture, and target alignment checking.
- Sits between the control unit and the instruction-memory address path.
- Replaces the separate PC mux, PC register and EPC register.

Parameters:
- WIDTH, 32, PC/data width in bits.
- NUM_SRC, 5, number of next-PC candidate inputs (2..16).
- SEL_W, 3, selector width; must satisfy 2**SEL_W >= NUM_SRC.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- EXC_VECTOR, 32'h0000_00FC, PC value loaded on exception or fault.
- ALIGN_CHECK, 1, 1 = targets with addr[1:0] != 0 fault; 0 = no check.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- selector  in  SEL_W  index of the candidate to load.
- src_data  in  NUM_SRC*WIDTH  flattened candidates; source i occupies [i*WIDTH +: WIDTH].
- pc_write  in  1  unconditional load request.
- pc_write_cond  in  1  branch load request, qualified by cond_flag.
- cond_flag  in  1  branch condition (e.g. ALU zero).
- exc_req  in  1  external exception request (overflow, opcode fault).
- pc_out  out  WIDTH  current PC.
- epc_out  out  WIDTH  PC captured at the last exception or fault.
- fault  out  1  one-cycle pulse: misaligned target or out-of-range selector.
- loaded  out  1  one-cycle pulse: a normal load occurred.

Behaviour:
- Reset (reset low, asynchronous, any time): pc_out=RESET_VECTOR, epc_out=0, fault=0, loaded=0. Any in-flight request is discarded. After release, the first rising edge with reset high acts normally.
- Load enable: load_en = pc_write | (pc_write_cond & cond_flag).
- Target: target = src_data slice [selector].
- Invalid selector: selector >= NUM_SRC is invalid; the target is never read.
- Misaligned: ALIGN_CHECK=1 and target[1:0] != 0.
- Per rising edge, priority highest first:
  1. exc_req=1: pc<=EXC_VECTOR, epc<=pc_out, fault<=0, loaded<=0. Any load request in the same cycle is dropped.
  2. load_en=1 and (invalid selector or misaligned): pc<=EXC_VECTOR, epc<=pc_out, fault<=1, loaded<=0.
  3. load_en=1 and valid: pc<=target, epc holds, fault<=0, loaded<=1.
  4. Otherwise: pc and epc hold, fault<=0, loaded<=0.
- Latency: a new PC appears on pc_out one cycle after the requesting edge. No combinational path from any input to pc_out or epc_out.
- Signal independence:
  - pc_write_cond with cond_flag=0 is a no-op.
  - cond_flag is ignored when pc_write=1.
  - selector and src_data are don't-care when load_en=0 and exc_req=0; no fault is raised for them.
- Wrap-around: no arithmetic is performed; targets of all-ones are loaded as-is when aligned.
- Back-to-back loads every cycle are supported. fault and loaded are never high together.

Decomposition:
- Shared package pc_pkg:
  - Source index constants: PC_SRC_ALU=0, PC_SRC_ALUOUT=1, PC_SRC_JUMP=2, PC_SRC_EPC=3, PC_SRC_MEM=4.
  - Default RESET_VECTOR and EXC_VECTOR.
- One sub-module, pc_src_mux: parametrised combinational N:1 selector with a valid flag for in-range indices.
- Registers, priority logic and alignment check stay in pc_source_reg.

Test Plan:
1. Reset low mid-run with pc_out=0x40, no clock edge needed: pc_out=0x0 and epc_out=0 immediately; after release plus one idle edge, pc_out=0x0.
2. selector=2, src2=0x0000_1000, pc_write=1: next cycle pc_out=0x1000, loaded=1 for one cycle, fault=0.
3. pc_write_cond=1, src0=0x200:
   - cond_flag=0: pc_out unchanged, loaded=0.
   - cond_flag=1: pc_out=0x200.
4. pc_out=0x1000, selector=1, src1=0x0000_1002, pc_write=1: pc_out=0xFC, epc_out=0x1000, fault=1 for one cycle. Same stimulus with ALIGN_CHECK=0: pc_out=0x1002.
5. pc_out=0x300, selector=6 with NUM_SRC=5, pc_write=1: pc_out=0xFC, epc_out=0x300, fault=1.
6. pc_out=0x500, exc_req=1 with pc_write=1 and a valid aligned target in the same cycle: pc_out=0xFC, epc_out=0x500, loaded=0, fault=0.
